sevenseg_frame_decoder: RTL

Receive-side counterpart of the stopwatch seven-segment encoder. Accepts a serial, time-multiplexed stream of six 8-bit segment patterns per frame, decodes each pattern back to a BCD digit, checks legality, and reassembles binary minutes, seconds and hundredths. Used for display loop-back checking and for sourcing the stopwatch time from a segment bus.

---
 rtl/sevenseg_pkg.sv | 36 +++
 rtl/sevenseg_digit_decode.sv | 36 +++
 rtl/sevenseg_frame_decoder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: active-low digit patterns, frame error codes,
// decoder state encoding and the decimal recombination helper.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_TENS_SEC = 2'b10;
  localparam logic [1:0] ERR_RESTART  = 2'b11;

  localparam logic [2:0] LAST_INDEX = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CONVERT = 2'd2
  } state_e;

  // 10*tens + units using shifts; both digits are at most 9 so 7 bits never overflow.
  function automatic logic [6:0] times10_plus(input logic [3:0] tens, input logic [3:0] units);
    logic [6:0] t;
    t = {3'b000, tens};
    return (t << 3) + (t << 1) + {3'b000, units};
  endfunction

endpackage

// File: rtl/sevenseg_digit_decode.sv
// Combinational decode of one active-low segment pattern to a BCD digit;
// the decimal point is ignored and unknown patterns are flagged illegal.
module sevenseg_digit_decode
  import sevenseg_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] digit,
  output logic       legal
);

  logic unused_dp;
  assign unused_dp = pattern[7];

  // Pattern lookup
  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    case (pattern[6:0])
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: begin
        digit = 4'd0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sevenseg_frame_decoder.sv
// Reassembles a six-beat seven-segment frame into binary minutes, seconds and
// hundredths, reporting illegal patterns, bad tens-of-seconds and restarted frames.
module sevenseg_frame_decoder
  import sevenseg_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] seg_data,
  input  logic       seg_valid,
  input  logic       seg_sof,
  output logic       seg_ready,
  output logic [6:0] stopwatch_unit_mins,
  output logic [5:0] stopwatch_unit_secs,
  output logic [6:0] stopwatch_unit_decs,
  output logic       frame_valid,
  output logic       frame_error,
  output logic [1:0] err_code
);

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0][3:0] digits_q, digits_d;
  logic            illegal_q, illegal_d;
  logic            abort_q, abort_d;
  logic            seg_ready_q, seg_ready_d;
  logic [6:0]      mins_q, mins_d;
  logic [5:0]      secs_q, secs_d;
  logic [6:0]      decs_q, decs_d;
  logic            frame_valid_q, frame_valid_d;
  logic            frame_error_q, frame_error_d;
  logic [1:0]      err_code_q, err_code_d;

  logic [3:0]      dec_digit_s;
  logic            dec_legal_s;
  logic            beat_s;

  sevenseg_digit_decode u_digit_decode (
    .pattern (seg_data),
    .digit   (dec_digit_s),
    .legal   (dec_legal_s)
  );

  assign beat_s = seg_valid && seg_ready_q;

  // Next-state, digit capture, conversion and output-register computation
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    digits_d      = digits_q;
    illegal_d     = illegal_q;
    abort_d       = 1'b0;
    mins_d        = mins_q;
    secs_d        = secs_q;
    decs_d        = decs_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    err_code_d    = err_code_q;

    // A restart seen last cycle reports now; it can never coincide with CONVERT.
    if (abort_q) begin
      frame_error_d = 1'b1;
      err_code_d    = ERR_RESTART;
    end else begin
      frame_error_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (beat_s && seg_sof) begin
          digits_d[0] = dec_digit_s;
          idx_d       = 3'd1;
          illegal_d   = ~dec_legal_s;
          state_d     = ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_COLLECT: begin
        if (beat_s) begin
          if (seg_sof) begin
            abort_d     = 1'b1;
            digits_d[0] = dec_digit_s;
            idx_d       = 3'd1;
            illegal_d   = ~dec_legal_s;
          end else begin
            digits_d[idx_q] = dec_digit_s;
            illegal_d       = illegal_q | ~dec_legal_s;
            if (idx_q == LAST_INDEX) begin
              idx_d   = 3'd0;
              state_d = ST_CONVERT;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_CONVERT: begin
        state_d   = ST_IDLE;
        illegal_d = 1'b0;
        if (illegal_q) begin
          frame_error_d = 1'b1;
          err_code_d    = ERR_ILLEGAL;
        end else if (digits_q[2] > 4'd5) begin
          frame_error_d = 1'b1;
          err_code_d    = ERR_TENS_SEC;
        end else begin
          frame_valid_d = 1'b1;
          mins_d        = times10_plus(digits_q[0], digits_q[1]);
          secs_d        = 6'(times10_plus(digits_q[2], digits_q[3]));
          decs_d        = times10_plus(digits_q[4], digits_q[5]);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        idx_d     = 3'd0;
        illegal_d = 1'b0;
      end
    endcase

    seg_ready_d = (state_d != ST_CONVERT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= 3'd0;
      digits_q      <= '0;
      illegal_q     <= 1'b0;
      abort_q       <= 1'b0;
      seg_ready_q   <= 1'b1;
      mins_q        <= 7'd0;
      secs_q        <= 6'd0;
      decs_q        <= 7'd0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      digits_q      <= digits_d;
      illegal_q     <= illegal_d;
      abort_q       <= abort_d;
      seg_ready_q   <= seg_ready_d;
      mins_q        <= mins_d;
      secs_q        <= secs_d;
      decs_q        <= decs_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      err_code_q    <= err_code_d;
    end
  end

  assign seg_ready           = seg_ready_q;
  assign stopwatch_unit_mins = mins_q;
  assign stopwatch_unit_secs = secs_q;
  assign stopwatch_unit_decs = decs_q;
  assign frame_valid         = frame_valid_q;
  assign frame_error         = frame_error_q;
  assign err_code            = err_code_q;

endmodule
